flip_bits_master: RTL and testbench

Avalon-MM master sequencer that sits directly upstream of the bit-flip accelerator slave and drives its register map on behalf of a streaming client. It accepts one 32-bit job on a valid/ready input and runs the slave's command protocol: write input, issue command, wait, poll status, read result, clear status. It then returns the result, with an error flag, on a valid/ready output. Every bus access is a single cycle; there is no waitrequest, and read data is sampled in the same cycle as `read`.

---
 rtl/flip_bits_master.sv | 101 ++++++++++
 tb/tb_flip_bits_master.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/flip_bits_master.sv
// flip_bits_master: Avalon-MM sequencer that runs one bit-flip job on the slave per streamed request
module flip_bits_master #(
  parameter logic [7:0]  ADDR_CMD      = 8'd1,
  parameter logic [7:0]  ADDR_STATUS   = 8'd2,
  parameter logic [7:0]  ADDR_INP      = 8'd3,
  parameter logic [7:0]  ADDR_OUTP     = 8'd4,
  parameter logic [31:0] CMD_CODE      = 32'd1,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          POLL_LIMIT    = 64
) (
  input  logic        clock_sink_clk,
  input  logic        reset_sink_reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_error,
  input  logic        out_ready,
  output logic [7:0]  avalon_master_address,
  output logic        avalon_master_read,
  input  logic [31:0] avalon_master_readdata,
  output logic        avalon_master_write,
  output logic [31:0] avalon_master_writedata,
  output logic        busy,
  output logic [15:0] job_count,
  output logic [15:0] timeout_count
);
  typedef enum logic [2:0] {IDLE, WR_INP, WR_CMD, SETTLE, POLL, RD_OUT, CLR, OUT} state_t;
  state_t state, state_nx;
  logic [31:0] job, result;
  logic err;
  logic [15:0] settle_cnt, poll_cnt;
  logic hit, last_poll, settled;
  assign hit = avalon_master_readdata[0];
  assign last_poll = poll_cnt == 16'(POLL_LIMIT - 1);
  assign settled = settle_cnt == 16'(SETTLE_CYCLES - 1);
  assign out_data = result;
  assign out_error = err;
  always_ff @(posedge clock_sink_clk)
    if (reset_sink_reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? WR_INP : IDLE;
      WR_INP:  state_nx = WR_CMD;
      WR_CMD:  state_nx = SETTLE;
      SETTLE:  state_nx = settled ? POLL : SETTLE;
      POLL:    state_nx = hit ? RD_OUT : last_poll ? CLR : POLL;
      RD_OUT:  state_nx = CLR;
      CLR:     state_nx = OUT;
      OUT:     state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    avalon_master_read = state == POLL || state == RD_OUT;
    avalon_master_write = state == WR_INP || state == WR_CMD || state == CLR;
    avalon_master_address = state == WR_INP ? ADDR_INP :
                            state == WR_CMD ? ADDR_CMD :
                            state == POLL || state == CLR ? ADDR_STATUS :
                            state == RD_OUT ? ADDR_OUTP : 8'd0;
    avalon_master_writedata = state == WR_INP ? job : state == WR_CMD ? CMD_CODE : 32'd0;
    in_ready = state == IDLE && !reset_sink_reset;
    out_valid = state == OUT;
    busy = state != IDLE;
  end
  // The status read data is sampled in the same cycle as the POLL strobe.
  always_ff @(posedge clock_sink_clk)
    if (reset_sink_reset) begin
      job <= 32'd0;
      result <= 32'd0;
      err <= 1'b0;
      settle_cnt <= 16'd0;
      poll_cnt <= 16'd0;
      job_count <= 16'd0;
      timeout_count <= 16'd0;
    end else begin
      if (state == IDLE && in_valid) begin
        job <= in_data;
        result <= 32'd0;
        err <= 1'b0;
      end
      if (state == WR_CMD) begin
        settle_cnt <= 16'd0;
        poll_cnt <= 16'd0;
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + 16'd1;
      if (state == POLL && !hit && !last_poll) poll_cnt <= poll_cnt + 16'd1;
      if (state == POLL && !hit && last_poll) begin
        err <= 1'b1;
        result <= 32'd0;
      end
      if (state == RD_OUT) result <= avalon_master_readdata;
      if (state == CLR) begin
        job_count <= job_count + 16'd1;
        timeout_count <= timeout_count + {15'd0, err};
      end
    end
endmodule

// File: tb/tb_flip_bits_master.sv
// tb_flip_bits_master: random jobs against a bit-flip slave model, timeline reference and result scoreboard
module tb_flip_bits_master;
  localparam int S = 4;
  localparam int L = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_error, rd, wr, busy;
  logic [31:0] out_data, rdata, wdata;
  logic [7:0] addr;
  logic [15:0] job_count, timeout_count;
  flip_bits_master #(.SETTLE_CYCLES(S), .POLL_LIMIT(L)) dut (
    .clock_sink_clk(clk), .reset_sink_reset(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_error(out_error), .out_ready(out_ready),
    .avalon_master_address(addr), .avalon_master_read(rd), .avalon_master_readdata(rdata),
    .avalon_master_write(wr), .avalon_master_writedata(wdata),
    .busy(busy), .job_count(job_count), .timeout_count(timeout_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // slave: output = ~input; status goes to 1 after slv_h zero polls since the last command
  logic [31:0] slv_inp = 0;
  int slv_polls = 0, slv_h = 0;
  always @(posedge clk) begin
    if (wr && addr == 8'd3) slv_inp <= wdata;
    if (wr && addr == 8'd1) slv_polls <= 0;
    else if (rd && addr == 8'd2) slv_polls <= slv_polls + 1;
  end
  assign rdata = !rd ? 32'd0 : addr == 8'd4 ? ~slv_inp : addr == 8'd2 ? 32'(slv_polls >= slv_h) : 32'd0;
  int or_mode = 0;
  always @(posedge clk) begin
    #1;
    out_ready = or_mode == 2 ? ($urandom_range(0, 3) != 0) : or_mode == 0;
  end
  typedef struct packed {logic [31:0] d; logic e;} res_t;
  res_t q[$];
  int total = 0, bad = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, a, e);
    end
  endtask
  logic act = 0, succ = 0, was_rst = 0, eout, eir, er, ew;
  int acc = 0, p = 0, c = 0, jobs = 0, tos = 0, o;
  logic [31:0] jd = 0, ea, ewd;
  always @(negedge clk) begin
    o = cyc - acc;
    ea = 0; er = 0; ew = 0; ewd = 0;
    eout = act && o > c;
    eir = !act && !rst;
    if (act && o == 1) begin ew = 1; ea = 3; ewd = jd; end
    else if (act && o == 2) begin ew = 1; ea = 1; ewd = 1; end
    else if (act && o >= 3 + S && o < 3 + S + p) begin er = 1; ea = 2; end
    else if (act && succ && o == 3 + S + p) begin er = 1; ea = 4; end
    else if (act && o == c) begin ew = 1; ea = 2; end
    chk("address", {24'd0, addr}, ea);
    chk("read", {31'd0, rd}, {31'd0, er});
    chk("write", {31'd0, wr}, {31'd0, ew});
    chk("writedata", wdata, ewd);
    chk("busy", {31'd0, busy}, {31'd0, act});
    chk("in_ready", {31'd0, in_ready}, {31'd0, eir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, eout});
    chk("job_count", {16'd0, job_count}, 32'(jobs));
    chk("timeout_count", {16'd0, timeout_count}, 32'(tos));
    if (eout) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty cyc=%0d got=%h want=expected_entry", cyc, out_data);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_error", {31'd0, out_error}, {31'd0, q[0].e});
      end
    end
    if (was_rst) begin
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_error", {31'd0, out_error}, 32'd0);
    end
    if (act && o == c) begin jobs++; tos += succ ? 0 : 1; end
    if (eout && out_ready) begin act = 0; if (q.size() != 0) void'(q.pop_front()); end
    if (in_valid && eir) begin
      act = 1; acc = cyc; jd = in_data;
      p = slv_h + 1 < L ? slv_h + 1 : L;
      succ = slv_h < L;
      c = 3 + S + p + (succ ? 1 : 0);
    end
    was_rst = rst;
    if (rst) begin act = 0; q.delete(); jobs = 0; tos = 0; end
  end
  task automatic send(logic [31:0] d, int h);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(in_ready || out_valid) && n < 400);
    @(posedge clk); #1;
    in_valid = 1; in_data = d; slv_h = h;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 400);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout cyc=%0d got=in_ready_0 want=in_ready_1", cyc);
    end else q.push_back('{d: h < L ? ~d : 32'd0, e: h >= L});
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || q.size() != 0) && n < 1000);
    if (busy || q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain cyc=%0d got=pending_%0d want=pending_0", cyc, q.size());
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end
  initial begin
    int r, h, n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    send(32'h0000FFFF, 0);
    send(32'h12345678, 0);
    send(32'hA5A5A5A5, 0);
    send($urandom, 1000);
    send($urandom, 3);
    drain();
    @(negedge clk); or_mode = 1;
    send(32'hCAFEF00D, 0);
    fork
      send(32'h0F0F1234, 2);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 400);
        repeat (20) @(negedge clk);
        or_mode = 0;
      end
    join
    drain();
    send(32'h55AA33CC, 1000);
    repeat (7) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    send(32'h89ABCDEF, 0);
    drain();
    @(negedge clk); or_mode = 2;
    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 5);
      h = r == 0 ? 0 : r == 1 ? 3 : r == 2 ? L - 1 : r == 3 ? L : r == 4 ? $urandom_range(0, 12) : 1000;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send($urandom, h);
    end
    @(negedge clk); or_mode = 0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
